// File: rtl/clock_ctrl_pkg.sv
// rtl/clock_ctrl_pkg.sv - shared mode encoding and helpers for the mm:ss clock controller
package clock_ctrl_pkg;

  typedef enum logic [1:0] {
    MODE_RUN     = 2'd0,
    MODE_SET_MIN = 2'd1,
    MODE_SET_SEC = 2'd2
  } mode_t;

  // Width of the auto-repeat hold counter
  localparam int unsigned HOLD_W = 32;

  function automatic logic is_set_mode(input mode_t m);
    return (m == MODE_SET_MIN) || (m == MODE_SET_SEC);
  endfunction

  // Mode button cycles RUN -> SET_MIN -> SET_SEC -> RUN
  function automatic mode_t next_mode(input mode_t m);
    case (m)
      MODE_RUN:     return MODE_SET_MIN;
      MODE_SET_MIN: return MODE_SET_SEC;
      default:      return MODE_RUN;
    endcase
  endfunction

endpackage

// File: rtl/clock_ctrl_tick_gen.sv
// rtl/clock_ctrl_tick_gen.sv - prescaler producing a one-cycle tick every TICK_DIV clocks
module tick_gen #(
  parameter int unsigned TICK_DIV = 100_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int unsigned CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // tick is decoded from the terminal count so it lines up with the wrap
  assign tick = (cnt_q == LAST);

  // Next count: wrap at the terminal count, or restart from zero on clr
  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (clr || tick) begin
      cnt_d = '0;
    end
  end

  // Prescaler register
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/clock_ctrl.sv
// rtl/clock_ctrl.sv - run/set mode FSM, 1 Hz enable and carry gating; auto-repeat under CLOCK_CTRL_AUTOREPEAT_EN
module clock_ctrl
  import clock_ctrl_pkg::*;
#(
  parameter int unsigned TICK_DIV   = 100_000_000,
  parameter int unsigned RPT_DLY    = 50_000_000,
  parameter int unsigned RPT_PERIOD = 10_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_mode,
  input  logic       btn_set,
  input  logic       sec_co,
  input  logic       min_co,
  output logic       sec_en,
  output logic       sec_inc,
  output logic       min_en,
  output logic       min_inc,
  output logic       hour_en,
  output logic [1:0] mode,
  output logic       blink
);

  if (TICK_DIV < 2 || RPT_DLY < 1 || RPT_PERIOD < 1) begin : g_bad_params
    $error("clock_ctrl: TICK_DIV must be >= 2 and RPT_DLY/RPT_PERIOD >= 1");
  end

  mode_t state_q, state_d;
  logic  btn_mode_q, btn_mode_d;
  logic  btn_set_q, btn_set_d;
  logic  sec_en_q, sec_en_d;
  logic  sec_inc_q, sec_inc_d;
  logic  min_inc_q, min_inc_d;
  logic  blink_q, blink_d;
  logic  mode_edge, set_edge, tick, clr, fire;

  // The mode edge has priority, so a coincident set edge is dropped
  assign mode_edge = btn_mode & ~btn_mode_q;
  assign set_edge  = btn_set & ~btn_set_q & ~mode_edge;

  // Leaving SET_SEC restarts the second so the first one after setting is full length
  assign clr = mode_edge & (state_q == MODE_SET_SEC);

  tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr),
    .tick (tick)
  );

`ifdef CLOCK_CTRL_AUTOREPEAT_EN
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              held;

  // A hold only counts while setting and with no mode change this cycle
  assign held = btn_set & btn_set_q & ~mode_edge & is_set_mode(state_q);

  // Hold counter: first repeat at RPT_DLY, then fold back so repeats recur every RPT_PERIOD
  always_comb begin
    hold_d = '0;
    fire   = 1'b0;
    if (held) begin
      hold_d = hold_q + HOLD_W'(1);
      if (hold_d == HOLD_W'(RPT_DLY)) begin
        fire = 1'b1;
      end else if (hold_d == HOLD_W'(RPT_DLY + RPT_PERIOD)) begin
        fire   = 1'b1;
        hold_d = HOLD_W'(RPT_DLY);
      end
    end
  end

  // Hold counter register
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_q <= '0;
    end else begin
      hold_q <= hold_d;
    end
  end
`else
  assign fire = 1'b0;
`endif

  // Next state and registered outputs of the mode FSM
  always_comb begin
    btn_mode_d = btn_mode;
    btn_set_d  = btn_set;
    state_d    = state_q;
    blink_d    = blink_q;
    sec_en_d   = tick & (state_q == MODE_RUN) & ~mode_edge;
    min_inc_d  = (state_q == MODE_SET_MIN) & (set_edge | fire);
    sec_inc_d  = (state_q == MODE_SET_SEC) & (set_edge | fire);
    if (is_set_mode(state_q) && tick) begin
      blink_d = ~blink_q;
    end
    if (mode_edge) begin
      state_d = next_mode(state_q);
      if (state_d == MODE_RUN) begin
        blink_d = 1'b0;
      end
    end
  end

  // FSM state, button history and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= MODE_RUN;
      btn_mode_q <= 1'b0;
      btn_set_q  <= 1'b0;
      sec_en_q   <= 1'b0;
      sec_inc_q  <= 1'b0;
      min_inc_q  <= 1'b0;
      blink_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      btn_mode_q <= btn_mode_d;
      btn_set_q  <= btn_set_d;
      sec_en_q   <= sec_en_d;
      sec_inc_q  <= sec_inc_d;
      min_inc_q  <= min_inc_d;
      blink_q    <= blink_d;
    end
  end

  assign sec_en  = sec_en_q;
  assign sec_inc = sec_inc_q;
  assign min_inc = min_inc_q;
  assign blink   = blink_q;
  assign mode    = state_q;
  assign min_en  = sec_co & (state_q == MODE_RUN);
  assign hour_en = min_co & (state_q == MODE_RUN);

endmodule

// File: tb/tb_clock_ctrl.sv
// tb/tb_clock_ctrl.sv - self-checking bench for clock_ctrl with directed and randomized stimulus
module tb_clock_ctrl;

  localparam int TD = 10;
  localparam int RD = 20;
  localparam int RP = 5;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       btn_mode = 1'b0;
  logic       btn_set = 1'b0;
  logic       sec_co = 1'b0;
  logic       min_co = 1'b0;
  logic       sec_en, sec_inc, min_en, min_inc, hour_en, blink;
  logic [1:0] mode;

  clock_ctrl #(
    .TICK_DIV   (TD),
    .RPT_DLY    (RD),
    .RPT_PERIOD (RP)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .btn_mode (btn_mode),
    .btn_set  (btn_set),
    .sec_co   (sec_co),
    .min_co   (min_co),
    .sec_en   (sec_en),
    .sec_inc  (sec_inc),
    .min_en   (min_en),
    .min_inc  (min_inc),
    .hour_en  (hour_en),
    .mode     (mode),
    .blink    (blink)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: time-based view of the controller
  int e       = 0;   // posedges seen
  int t0      = 0;   // edge at which the current second started
  int ref_e   = 0;   // last edge at which the set button was not being held
  int m_state = 0;
  bit m_blink = 0;
  bit pm = 0, ps = 0;
  bit x_sec_en = 0, x_sec_inc = 0, x_min_inc = 0;

  int n_sec_en = 0, n_sec_inc = 0, n_min_inc = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic model_edge(input bit r, input bit m, input bit s);
    bit wrap, me, se, fire;
`ifdef CLOCK_CTRL_AUTOREPEAT_EN
    int d;
`endif
    e++;
    if (r) begin
      m_state = 0; t0 = e; ref_e = e; m_blink = 0; pm = 0; ps = 0;
      x_sec_en = 0; x_sec_inc = 0; x_min_inc = 0;
      return;
    end
    wrap = ((e - t0) % TD) == 0;
    me   = m && !pm;
    se   = s && !ps && !me;
    fire = 0;
`ifdef CLOCK_CTRL_AUTOREPEAT_EN
    if ((m_state != 0) && s && ps && !me) begin
      d    = e - ref_e;
      fire = (d == RD) || ((d > RD) && ((d - RD) % RP == 0));
    end else begin
      ref_e = e;
    end
`endif
    x_sec_en  = wrap && (m_state == 0) && !me;
    x_min_inc = (m_state == 1) && (se || fire);
    x_sec_inc = (m_state == 2) && (se || fire);
    if (m_state != 0 && wrap) m_blink = !m_blink;
    if (me) begin
      m_state = (m_state + 1) % 3;
      if (m_state == 0) begin
        t0 = e;
        m_blink = 0;
      end
    end
    pm = m;
    ps = s;
  endtask

  task automatic cyc(input bit r, input bit m, input bit s, input bit sc, input bit mc);
    rst = r; btn_mode = m; btn_set = s; sec_co = sc; min_co = mc;
    #1;
    check("min_en", min_en, 32'(sc && (m_state == 0)));
    check("hour_en", hour_en, 32'(mc && (m_state == 0)));
    @(posedge clk);
    model_edge(r, m, s);
    #1;
    check("mode", mode, m_state);
    check("sec_en", sec_en, 32'(x_sec_en));
    check("sec_inc", sec_inc, 32'(x_sec_inc));
    check("min_inc", min_inc, 32'(x_min_inc));
    check("blink", blink, 32'(m_blink));
    if (sec_en === 1'b1) n_sec_en++;
    if (sec_inc === 1'b1) n_sec_inc++;
    if (min_inc === 1'b1) n_min_inc++;
  endtask

  task automatic clr_counts();
    n_sec_en = 0; n_sec_inc = 0; n_min_inc = 0;
  endtask

  initial begin
    int  k;
    int  last_tog;
    bit  prev_blink;
    bit  rm, rs, sc, mc, rr;

    // Reset, then free-run in RUN
    repeat (3) cyc(1, 0, 0, 0, 0);
    check("reset_outputs", {sec_en, sec_inc, min_en, min_inc, hour_en, blink, mode}, 0);
    clr_counts();
    repeat (100) cyc(0, 0, 0, 0, 0);
    check("run_sec_en_count", n_sec_en, 10);

    // Carries during a sec_en cycle
    k = 0;
    while (sec_en !== 1'b1 && k < 30) begin
      cyc(0, 0, 0, 0, 0);
      k++;
    end
    check("sec_en_found", 32'(k < 30), 1);
    cyc(0, 0, 0, 1, 1);
    cyc(0, 0, 0, 0, 0);

    // Mode cycling with blink spacing
    clr_counts();
    cyc(0, 1, 0, 0, 0);
    check("mode_set_min", mode, 1);
    last_tog = -1;
    prev_blink = blink;
    for (int i = 0; i < 49; i++) begin
      if (i == 24) cyc(0, 1, 0, 0, 0);
      else         cyc(0, 0, 0, 0, 0);
      if (i == 24) check("mode_set_sec", mode, 2);
      if (blink !== prev_blink) begin
        if (last_tog >= 0) check("blink_period", e - last_tog, TD);
        last_tog = e;
      end
      prev_blink = blink;
    end
    check("no_sec_en_in_set", n_sec_en, 0);
    cyc(0, 1, 0, 0, 0);
    check("mode_back_run", mode, 0);
    k = 0;
    do begin
      cyc(0, 0, 0, 0, 0);
      k++;
    end while (sec_en !== 1'b1 && k < 30);
    check("first_sec_en_after_set", k, TD);

    // Mode edge on the wrap cycle suppresses sec_en
    k = 0;
    while (((e + 1 - t0) % TD) != 0 && k < 30) begin
      cyc(0, 0, 0, 0, 0);
      k++;
    end
    cyc(0, 1, 0, 0, 0);
    check("sec_en_suppressed", sec_en, 0);
    cyc(0, 0, 0, 0, 0);

    // Test A: three set presses in SET_MIN
    clr_counts();
    repeat (3) begin
      cyc(0, 0, 1, 0, 0);
      cyc(0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0);
    end
    check("testa_min_inc", n_min_inc, 3);
    check("testa_sec_inc", n_sec_inc, 0);

    // Test B: long hold in SET_MIN
    clr_counts();
    repeat (40) cyc(0, 0, 1, 0, 0);
    repeat (3) cyc(0, 0, 0, 0, 0);
`ifdef CLOCK_CTRL_AUTOREPEAT_EN
    check("testb_min_inc", n_min_inc, 5);
`else
    check("testb_min_inc", n_min_inc, 1);
`endif

    // Hold 38 cycles in SET_SEC
    cyc(0, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    check("mode_set_sec2", mode, 2);
    clr_counts();
    repeat (38) cyc(0, 0, 1, 0, 0);
    repeat (3) cyc(0, 0, 0, 0, 0);
`ifdef CLOCK_CTRL_AUTOREPEAT_EN
    check("hold38_sec_inc", n_sec_inc, 5);
`else
    check("hold38_sec_inc", n_sec_inc, 1);
`endif

    // Simultaneous mode and set edges in SET_SEC
    clr_counts();
    cyc(0, 1, 1, 0, 0);
    check("simul_mode", mode, 0);
    cyc(0, 0, 0, 0, 0);
    check("simul_no_sec_inc", n_sec_inc, 0);

    // Reset in SET_MIN
    cyc(0, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    check("pre_reset_mode", mode, 1);
    cyc(1, 0, 0, 0, 0);
    check("mid_reset_outputs", {sec_en, sec_inc, min_en, min_inc, hour_en, blink, mode}, 0);
    cyc(0, 0, 0, 0, 0);

    // Randomized traffic against the model
    rm = 0; rs = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(19) == 0) rm = !rm;
      if ($urandom_range(29) == 0) rs = !rs;
      sc = ($urandom_range(3) == 0);
      mc = ($urandom_range(3) == 0);
      rr = ($urandom_range(399) == 0);
      cyc(rr, rm, rs, sc, mc);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
